wb_ram: RTL and testbench
=========================

WB_RAM -- requirements
Module: wb_ram

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of word count (DEPTH = 2**DEPTH_LOG2 words of 32 bits), legal range 4..16.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, meaning extra wait states inserted before each non-burst acknowledge, legal range 0..15.
Ports:
REQ-003 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 adr_i  input  30  Wishbone word address.
REQ-006 dat_i  input  32  write data.
REQ-007 sel_i  input  4  byte-lane selects; bit n covers dat[8n+7:8n].
REQ-008 cyc_i, stb_i, we_i  input  1 each  Wishbone cycle, strobe, write-enable.
REQ-009 cti_i  input  3  Wishbone cycle-type identifier (used only with WB_RAM_BURST_EN).
REQ-010 ack_o  output  1  transfer acknowledge, registered.
REQ-011 err_o  output  1  transfer error (address out of range), registered.
REQ-012 dat_o  output  32  read data, registered.

Function
REQ-013 Storage SHALL be four byte-wide banks of DEPTH entries, indexed by the internal word address ADDR = adr_i[DEPTH_LOG2-1:0].
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; IDLE→WAIT when cyc_i&stb_i sampled high and WAIT_CYCLES>0, IDLE→RESP directly when WAIT_CYCLES=0.
REQ-015 WAIT SHALL count WAIT_CYCLES cycles, then go to RESP; total latency from first sampled strobe to ack_o high = WAIT_CYCLES+1 cycles.
REQ-016 In RESP exactly one of ack_o/err_o SHALL be high for one cycle; next state IDLE (classic cycle), so non-burst back-to-back transfers take WAIT_CYCLES+2 cycles each.
REQ-017 err_o SHALL be asserted instead of ack_o when adr_i[29:DEPTH_LOG2] is nonzero; no memory write SHALL occur and dat_o SHALL be 0.
REQ-018 A write SHALL commit only on the edge that raises ack_o, updating only lanes with sel_i set, using adr_i/dat_i/sel_i sampled that edge.
REQ-019 A read SHALL load dat_o on the edge that raises ack_o: selected lanes from the banks, unselected lanes 8'h00; dat_o SHALL otherwise hold its value.
REQ-020 If cyc_i or stb_i drops in WAIT, the FSM SHALL return to IDLE with no ack_o, no err_o and no write (abort).
REQ-021 sel_i=4'b0000 SHALL still acknowledge, writing nothing and returning dat_o=0 on reads.
REQ-022 ack_o and err_o SHALL never be high in the same cycle, and SHALL be 0 whenever the FSM is not in RESP.

Reset
REQ-023 On sys_rst high, asynchronously: state IDLE, wait counter 0, ack_o=0, err_o=0, dat_o=32'h0, burst address register 0.
REQ-024 Reset mid-transfer SHALL abandon it with no write; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-025 Macro WB_RAM_BURST_EN SHALL enable incrementing bursts; without it cti_i SHALL be ignored and every transfer is classic per REQ-014..REQ-016.
REQ-026 With WB_RAM_BURST_EN: in RESP, if cti_i=3'b010 and cyc_i&stb_i high, the FSM SHALL stay in RESP and acknowledge the next beat in the following cycle with zero wait states, using an internal address = previous ADDR+1, wrapping modulo DEPTH.
REQ-027 With WB_RAM_BURST_EN: the beat with cti_i=3'b111 SHALL be the last (next state IDLE); an out-of-range starting address SHALL err_o the first beat and end the burst.

Verification
REQ-028 WAIT_CYCLES=0: write adr 0x5, dat 0xDEADBEEF, sel 4'hF -> ack_o one cycle after strobe; read adr 0x5 -> dat_o=0xDEADBEEF with ack.
REQ-029 Byte mask: preload 0x11223344 at adr 0x7, write 0xAABBCCDD sel 4'b0101 -> read sel 4'hF returns 0x11BB33DD; read sel 4'b0011 returns 0x000033DD.
REQ-030 WAIT_CYCLES=3: read strobe at cycle 0 -> ack_o at cycle 4; drop stb_i at cycle 2 on a write -> no ack_o, memory unchanged.
REQ-031 DEPTH_LOG2=12: access adr 0x1000 -> err_o one pulse, ack_o 0, dat_o 0, word 0x000 unchanged.
REQ-032 WB_RAM_BURST_EN, DEPTH_LOG2=4: 4-beat write burst from adr 0xE (cti 010,010,010,111) -> acks on 4 consecutive cycles, words 0xE,0xF,0x0,0x1 written.
REQ-033 Assert sys_rst during WAIT of a write -> ack_o/err_o/dat_o zero immediately, no write, next transfer served normally.

Source files
------------

// File: rtl/wb_ram_if.sv
// rtl/wb_ram_if.sv - Wishbone bus bundle between a master and the wb_ram slave
// Signals: adr_i/dat_i/sel_i/cyc_i/stb_i/we_i/cti_i (master to slave),
//          ack_o/err_o/dat_o (slave to master). Suffixes are from the slave's view.
interface wb_ram_if;
    logic [29:0] adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [2:0]  cti_i;
    logic        ack_o;
    logic        err_o;
    logic [31:0] dat_o;

    modport master (
        output adr_i, dat_i, sel_i, cyc_i, stb_i, we_i, cti_i,
        input  ack_o, err_o, dat_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, cyc_i, stb_i, we_i, cti_i,
        output ack_o, err_o, dat_o
    );
endinterface

// File: rtl/wb_ram.sv
// rtl/wb_ram.sv - Wishbone slave RAM with byte lanes, wait states and optional bursts
// Parameters: DEPTH_LOG2 (log2 of 32-bit word count, 4..16), WAIT_CYCLES (0..15).
// Ports: sys_clk (rising edge), sys_rst (asynchronous, active-high),
//        wb (wb_ram_if.slave: address, data, lane selects, cyc/stb/we, cti, ack/err/data out).
// Build option: define WB_RAM_BURST_EN for incrementing bursts (cti 3'b010, ended by 3'b111);
//        without it cti_i is ignored and every transfer is classic.
module wb_ram #(
    parameter int DEPTH_LOG2  = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    wb_ram_if.slave wb
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_nxt;

    logic                  req;
    logic                  out_of_range;
    logic                  fire;        // a beat is accepted on this edge
    logic [DEPTH_LOG2-1:0] beat_addr;   // word the accepted beat targets
    logic                  beat_err;
    logic                  wr_en;
    logic [31:0]           rd_masked;

    logic                  ack_q;
    logic                  err_q;
    logic [31:0]           dat_q;

    assign req          = wb.cyc_i & wb.stb_i;
    assign out_of_range = |wb.adr_i[29:DEPTH_LOG2];

`ifdef WB_RAM_BURST_EN
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    logic [DEPTH_LOG2-1:0] burst_adr;   // word of the last accepted beat
    logic                  burst_cont;  // last beat announced more beats to follow
`else
    logic unused_cti;
    assign unused_cti = ^wb.cti_i;
`endif

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fire         = 1'b0;
        beat_addr    = wb.adr_i[DEPTH_LOG2-1:0];
        beat_err     = out_of_range;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        fire      = 1'b1;
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    // Master gave up before we answered: no response, no write.
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = 4'd0;
                end else if (wait_cnt == 4'(WAIT_CYCLES - 1)) begin
                    fire         = 1'b1;
                    state_nxt    = ST_RESP;
                    wait_cnt_nxt = 4'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
`ifdef WB_RAM_BURST_EN
                // Continuation beats ignore adr_i and walk the internal address,
                // wrapping at DEPTH; they cannot go out of range.
                if (burst_cont && req && (wb.cti_i == CTI_INCR || wb.cti_i == CTI_END)) begin
                    fire      = 1'b1;
                    state_nxt = ST_RESP;
                    beat_addr = burst_adr + 1'b1;
                    beat_err  = 1'b0;
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset is folded in so an edge coinciding with reset can never write.
    assign wr_en = fire & wb.we_i & ~beat_err & ~sys_rst;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] bank [DEPTH];

        always_ff @(posedge sys_clk) begin
            if (wr_en && wb.sel_i[g]) begin
                bank[beat_addr] <= wb.dat_i[8*g +: 8];
            end
        end

        assign rd_masked[8*g +: 8] = wb.sel_i[g] ? bank[beat_addr] : 8'h00;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= 32'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            ack_q    <= fire & ~beat_err;
            err_q    <= fire & beat_err;
            if (fire) begin
                if (beat_err) begin
                    dat_q <= 32'h0;
                end else if (!wb.we_i) begin
                    dat_q <= rd_masked;
                end
            end
        end
    end

`ifdef WB_RAM_BURST_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            burst_adr  <= '0;
            burst_cont <= 1'b0;
        end else begin
            if (fire) begin
                burst_adr <= beat_addr;
            end
            // An errored first beat ends the burst.
            burst_cont <= fire && (wb.cti_i == CTI_INCR) && !beat_err;
        end
    end
`endif

    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.dat_o = dat_q;
endmodule

// File: tb/tb_wb_ram.sv
// tb/tb_wb_ram.sv - randomized self-checking bench for wb_ram against a behavioural model
module tb_wb_ram;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    wb_ram_if bus0();
    wb_ram_if bus3();

    wb_ram #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) u_ram0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .wb(bus0));
    wb_ram #(.DEPTH_LOG2(4),  .WAIT_CYCLES(3)) u_ram3 (.sys_clk(sys_clk), .sys_rst(sys_rst), .wb(bus3));

    int checks   = 0;
    int failures = 0;

    logic [31:0] m0 [64];
    logic [31:0] m3 [16];
    logic [31:0] last_dat [2];

    function automatic int wait_of(input int dut);
        return (dut == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int l = 0; l < 4; l++) m[8*l +: 8] = {8{sel[l]}};
        return m;
    endfunction

    function automatic logic [31:0] mem_rd(input int dut, input int a);
        if (dut == 0) return m0[a];
        return m3[a];
    endfunction

    task automatic mem_wr(input int dut, input int a, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] m;
        m = lane_mask(sel);
        if (dut == 0) m0[a] = (m0[a] & ~m) | (d & m);
        else          m3[a] = (m3[a] & ~m) | (d & m);
    endtask

    task automatic drive(input int dut, input logic cyc, input logic stb, input logic we,
                         input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic [2:0] cti);
        if (dut == 0) begin
            bus0.cyc_i = cyc; bus0.stb_i = stb; bus0.we_i = we;
            bus0.adr_i = adr; bus0.dat_i = dat; bus0.sel_i = sel; bus0.cti_i = cti;
        end else begin
            bus3.cyc_i = cyc; bus3.stb_i = stb; bus3.we_i = we;
            bus3.adr_i = adr; bus3.dat_i = dat; bus3.sel_i = sel; bus3.cti_i = cti;
        end
    endtask

    function automatic logic ack_of(input int dut);
        return (dut == 0) ? bus0.ack_o : bus3.ack_o;
    endfunction

    function automatic logic err_of(input int dut);
        return (dut == 0) ? bus0.err_o : bus3.err_o;
    endfunction

    function automatic logic [31:0] dat_of(input int dut);
        return (dut == 0) ? bus0.dat_o : bus3.dat_o;
    endfunction

    // Classic single transfer; lat = edges until a response (0 on timeout),
    // tail = response still present one edge later.
    task automatic xfer(input int dut, input logic we, input logic [29:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output int lat, output logic ack, output logic err,
                        output logic [31:0] rdata, output logic tail);
        lat = 0; ack = 1'b0; err = 1'b0; rdata = 32'h0; tail = 1'b0;
        @(negedge sys_clk);
        drive(dut, 1'b1, 1'b1, we, adr, dat, sel, 3'b000);
        for (int i = 1; i <= 40; i++) begin
            @(posedge sys_clk); #1;
            if (ack_of(dut) || err_of(dut)) begin
                lat = i; ack = ack_of(dut); err = err_of(dut); rdata = dat_of(dut);
                break;
            end
        end
        drive(dut, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        @(posedge sys_clk); #1;
        tail = ack_of(dut) | err_of(dut);
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ack_of(d), err_of(d), dat_of(d)} !== 34'h0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got ack=%b err=%b dat=%h want 0/0/0",
                         d, ack_of(d), err_of(d), dat_of(d));
            end
        end
        sys_rst = 1'b0;
        last_dat[0] = 32'h0;
        last_dat[1] = 32'h0;
    endtask

    task automatic test_init();
        int lat; logic ack, err, tail; logic [31:0] rd, d; int ok;
        ok = 0;
        for (int a = 0; a < 64; a++) begin
            d = $urandom;
            xfer(0, 1'b1, 30'(a), d, 4'hF, lat, ack, err, rd, tail);
            m0[a] = d;
            if (ack && !err && lat == 1) ok++;
        end
        for (int a = 0; a < 16; a++) begin
            d = $urandom;
            xfer(1, 1'b1, 30'(a), d, 4'hF, lat, ack, err, rd, tail);
            m3[a] = d;
            if (ack && !err && lat == 4) ok++;
        end
        checks++;
        if (ok !== 80) begin
            failures++;
            $display("FAIL init_writes: got %0d good acks want 80", ok);
        end
    endtask

    task automatic test_basic();
        int lat; logic ack, err, tail; logic [31:0] rd;
        xfer(0, 1'b1, 30'h5, 32'hDEADBEEF, 4'hF, lat, ack, err, rd, tail);
        mem_wr(0, 5, 32'hDEADBEEF, 4'hF);
        checks++;
        if ({ack, err, tail} !== 3'b100 || lat !== 1) begin
            failures++;
            $display("FAIL basic_write: got ack=%b err=%b tail=%b lat=%0d want 1/0/0 lat 1", ack, err, tail, lat);
        end
        xfer(0, 1'b0, 30'h5, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== 32'hDEADBEEF || ack !== 1'b1 || lat !== 1) begin
            failures++;
            $display("FAIL basic_read: got dat=%h ack=%b lat=%0d want DEADBEEF 1 1", rd, ack, lat);
        end
        last_dat[0] = 32'hDEADBEEF;
    endtask

    task automatic test_byte_mask();
        int lat; logic ack, err, tail; logic [31:0] rd;
        xfer(0, 1'b1, 30'h7, 32'h11223344, 4'hF, lat, ack, err, rd, tail);
        xfer(0, 1'b1, 30'h7, 32'hAABBCCDD, 4'b0101, lat, ack, err, rd, tail);
        mem_wr(0, 7, 32'h11223344, 4'hF);
        mem_wr(0, 7, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b0, 30'h7, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL mask_read_full: got %h want 11BB33DD", rd);
        end
        xfer(0, 1'b0, 30'h7, 32'h0, 4'b0011, lat, ack, err, rd, tail);
        checks++;
        if (rd !== 32'h000033DD) begin
            failures++;
            $display("FAIL mask_read_low: got %h want 000033DD", rd);
        end
        // Empty lane select: acknowledged, writes nothing, reads zero.
        xfer(0, 1'b1, 30'h7, 32'hFFFFFFFF, 4'b0000, lat, ack, err, rd, tail);
        checks++;
        if (ack !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL sel0_write_ack: got ack=%b err=%b want 1/0", ack, err);
        end
        xfer(0, 1'b0, 30'h7, 32'h0, 4'b0000, lat, ack, err, rd, tail);
        checks++;
        if (rd !== 32'h0 || ack !== 1'b1) begin
            failures++;
            $display("FAIL sel0_read: got dat=%h ack=%b want 0 1", rd, ack);
        end
        xfer(0, 1'b0, 30'h7, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== mem_rd(0, 7)) begin
            failures++;
            $display("FAIL sel0_no_write: got %h want %h", rd, mem_rd(0, 7));
        end
        last_dat[0] = mem_rd(0, 7);
    endtask

    task automatic test_wait_latency();
        int lat; logic ack, err, tail; logic [31:0] rd; int a;
        a = $urandom_range(0, 15);
        xfer(1, 1'b0, 30'(a), 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (lat !== 4 || ack !== 1'b1 || rd !== mem_rd(1, a) || tail !== 1'b0) begin
            failures++;
            $display("FAIL wait_read: got lat=%0d ack=%b dat=%h tail=%b want 4 1 %h 0",
                     lat, ack, rd, tail, mem_rd(1, a));
        end
        last_dat[1] = mem_rd(1, a);
    endtask

    task automatic test_abort();
        int lat; logic ack, err, tail; logic [31:0] rd; int resp;
        resp = 0;
        @(negedge sys_clk);
        drive(1, 1'b1, 1'b1, 1'b1, 30'h9, ~mem_rd(1, 9), 4'hF, 3'b000);
        @(posedge sys_clk); #1;
        if (bus3.ack_o || bus3.err_o) resp++;
        @(posedge sys_clk); #1;
        if (bus3.ack_o || bus3.err_o) resp++;
        drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        repeat (8) begin
            @(posedge sys_clk); #1;
            if (bus3.ack_o || bus3.err_o) resp++;
        end
        checks++;
        if (resp !== 0) begin
            failures++;
            $display("FAIL abort_no_resp: got %0d response cycles want 0", resp);
        end
        xfer(1, 1'b0, 30'h9, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== mem_rd(1, 9) || lat !== 4) begin
            failures++;
            $display("FAIL abort_no_write: got %h lat=%0d want %h lat 4", rd, lat, mem_rd(1, 9));
        end
        last_dat[1] = mem_rd(1, 9);
    endtask

    task automatic test_error();
        int lat; logic ack, err, tail; logic [31:0] rd;
        xfer(0, 1'b1, 30'h1000, 32'h5A5A5A5A, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if ({ack, err, tail} !== 3'b010 || lat !== 1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_range_dut0: got ack=%b err=%b tail=%b lat=%0d dat=%h want 0/1/0 lat 1 dat 0",
                     ack, err, tail, lat, rd);
        end
        xfer(0, 1'b0, 30'h0, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== mem_rd(0, 0)) begin
            failures++;
            $display("FAIL err_no_write_dut0: got %h want %h", rd, mem_rd(0, 0));
        end
        last_dat[0] = mem_rd(0, 0);
        xfer(1, 1'b0, 30'h13, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if ({ack, err} !== 2'b01 || lat !== 4 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_range_dut3: got ack=%b err=%b lat=%0d dat=%h want 0/1 lat 4 dat 0",
                     ack, err, lat, rd);
        end
        last_dat[1] = 32'h0;
    endtask

    task automatic test_back_to_back();
        int w, span, a; logic exp_ack;
        for (int d = 0; d < 2; d++) begin
            w    = wait_of(d);
            span = 3 * (w + 2) + w + 1;
            a    = $urandom_range(0, 15);
            @(negedge sys_clk);
            drive(d, 1'b1, 1'b1, 1'b0, 30'(a), 32'h0, 4'hF, 3'b000);
            for (int k = 1; k <= span; k++) begin
                @(posedge sys_clk); #1;
                exp_ack = (k >= w + 1) && ((k - (w + 1)) % (w + 2) == 0);
                checks++;
                if (ack_of(d) !== exp_ack || err_of(d) !== 1'b0 ||
                    (exp_ack && dat_of(d) !== mem_rd(d, a))) begin
                    failures++;
                    $display("FAIL b2b dut%0d cycle %0d: got ack=%b err=%b dat=%h want ack=%b err=0 dat=%h",
                             d, k, ack_of(d), err_of(d), dat_of(d), exp_ack, mem_rd(d, a));
                end
            end
            drive(d, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
            repeat (2) @(posedge sys_clk);
            last_dat[d] = mem_rd(d, a);
        end
    endtask

    task automatic test_random();
        int lat; logic ack, err, tail; logic [31:0] rd;
        int dut, a, exp_lat; logic oor, we; logic [29:0] adr; logic [31:0] d, exp_dat; logic [3:0] sel;
        for (int n = 0; n < 80; n++) begin
            dut = $urandom_range(0, 1);
            oor = ($urandom_range(0, 7) == 0);
            a   = (dut == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            if (!oor)          adr = 30'(a);
            else if (dut == 0) adr = (30'($urandom_range(1, 255)) << 12) | 30'(a);
            else               adr = (30'($urandom_range(1, 255)) << 4) | 30'(a);
            we  = 1'($urandom_range(0, 1));
            sel = 4'($urandom_range(0, 15));
            d   = $urandom;
            xfer(dut, we, adr, d, sel, lat, ack, err, rd, tail);
            exp_lat = wait_of(dut) + 1;
            if (oor) begin
                exp_dat = 32'h0;
            end else if (we) begin
                mem_wr(dut, a, d, sel);
                exp_dat = last_dat[dut];
            end else begin
                exp_dat = mem_rd(dut, a) & lane_mask(sel);
            end
            last_dat[dut] = exp_dat;
            checks++;
            if (ack !== !oor || err !== oor || lat !== exp_lat || rd !== exp_dat || tail !== 1'b0) begin
                failures++;
                $display("FAIL random #%0d dut%0d we=%b adr=%h sel=%b: got ack=%b err=%b lat=%0d dat=%h tail=%b want %b %b %0d %h 0",
                         n, dut, we, adr, sel, ack, err, lat, rd, tail, !oor, oor, exp_lat, exp_dat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic ack, err, tail; logic [31:0] rd;
        xfer(1, 1'b1, 30'h3, 32'hCAFEF00D, 4'hF, lat, ack, err, rd, tail);
        mem_wr(1, 3, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 30'h3, 32'h0, 4'hF, lat, ack, err, rd, tail);
        @(negedge sys_clk);
        drive(1, 1'b1, 1'b1, 1'b1, 30'h3, 32'h12345678, 4'hF, 3'b000);
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if ({bus3.ack_o, bus3.err_o, bus3.dat_o} !== 34'h0 || bus0.dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got ack=%b err=%b dat3=%h dat0=%h want all 0",
                     bus3.ack_o, bus3.err_o, bus3.dat_o, bus0.dat_o);
        end
        drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        last_dat[0] = 32'h0;
        last_dat[1] = 32'h0;
        xfer(1, 1'b0, 30'h3, 32'h0, 4'hF, lat, ack, err, rd, tail);
        checks++;
        if (rd !== 32'hCAFEF00D || ack !== 1'b1 || lat !== 4) begin
            failures++;
            $display("FAIL reset_mid_no_write: got dat=%h ack=%b lat=%0d want CAFEF00D 1 4", rd, ack, lat);
        end
        last_dat[1] = 32'hCAFEF00D;
    endtask

`ifdef WB_RAM_BURST_EN
    task automatic test_burst();
        int lat, got; logic ack, err, tail; logic [31:0] rd; logic [31:0] bd [4]; logic exp_ack;
        for (int k = 0; k < 4; k++) bd[k] = $urandom;
        @(negedge sys_clk);
        drive(1, 1'b1, 1'b1, 1'b1, 30'hE, bd[0], 4'hF, 3'b010);
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge sys_clk); #1;
            if (bus3.ack_o || bus3.err_o) begin got = i; break; end
        end
        checks++;
        if (got !== 4 || bus3.ack_o !== 1'b1) begin
            failures++;
            $display("FAIL burst_first_ack: got lat=%0d ack=%b want 4 1", got, bus3.ack_o);
        end
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) drive(1, 1'b1, 1'b1, 1'b1, 30'((14 + k) % 16), bd[k], 4'hF,
                             (k == 3) ? 3'b111 : 3'b010);
            else       drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
            @(posedge sys_clk); #1;
            exp_ack = (k < 4);
            checks++;
            if (bus3.ack_o !== exp_ack || bus3.err_o !== 1'b0) begin
                failures++;
                $display("FAIL burst_beat %0d: got ack=%b err=%b want %b 0", k, bus3.ack_o, bus3.err_o, exp_ack);
            end
        end
        for (int k = 0; k < 4; k++) mem_wr(1, (14 + k) % 16, bd[k], 4'hF);
        for (int k = 0; k < 4; k++) begin
            xfer(1, 1'b0, 30'((14 + k) % 16), 32'h0, 4'hF, lat, ack, err, rd, tail);
            checks++;
            if (rd !== mem_rd(1, (14 + k) % 16)) begin
                failures++;
                $display("FAIL burst_word %0d: got %h want %h", (14 + k) % 16, rd, mem_rd(1, (14 + k) % 16));
            end
        end
        @(negedge sys_clk);
        drive(1, 1'b1, 1'b1, 1'b1, 30'h10, 32'h0, 4'hF, 3'b010);
        got = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge sys_clk); #1;
            if (bus3.ack_o || bus3.err_o) begin got = i; break; end
        end
        checks++;
        if (got !== 4 || bus3.err_o !== 1'b1 || bus3.ack_o !== 1'b0) begin
            failures++;
            $display("FAIL burst_err_first: got lat=%0d ack=%b err=%b want 4 0 1", got, bus3.ack_o, bus3.err_o);
        end
        drive(1, 1'b1, 1'b1, 1'b1, 30'h11, 32'h0, 4'hF, 3'b010);
        @(posedge sys_clk); #1;
        drive(1, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 4'h0, 3'b000);
        checks++;
        if (bus3.ack_o !== 1'b0 || bus3.err_o !== 1'b0) begin
            failures++;
            $display("FAIL burst_err_ends: got ack=%b err=%b want 0 0", bus3.ack_o, bus3.err_o);
        end
        repeat (2) @(posedge sys_clk);
        last_dat[1] = 32'h0;
    endtask
`endif

    initial begin
        test_reset();
        test_init();
        test_basic();
        test_byte_mask();
        test_wait_latency();
        test_abort();
        test_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef WB_RAM_BURST_EN
        test_burst();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
